muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage. Its hi/lo outputs feed the write-back result-select multiplexer alongside the ALU and memory results.
- Controlled by a start/busy/done handshake, so the pipeline stalls on busy.
- Handles signed and unsigned MULT/DIV, plus direct MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when idle.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- a  input  WIDTH  multiplicand/dividend, or the MTHI/MTLO data.
- b  input  WIDTH  multiplier/divisor.
- flush  input  1  abort any in-flight operation.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when hi/lo have been updated by MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clocking: single clock domain (clk). Reset is synchronous and active-high.
- Reset (rst=1 at any edge, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- States:
  - IDLE: accepts start.
  - CALC: performs WIDTH iterations.
  - FIX: sign correction and HI/LO commit.
  - FIX always returns to IDLE.
- IDLE, start=1, op in {0..3}:
  - Latch |a| and |b| (signed ops) or raw a and b (unsigned ops).
  - Latch the result sign, and the remainder sign (sign of a).
  - Enter CALC; busy=1 from the next cycle.
- IDLE, start=1, op=4: hi<=a at that edge; busy stays 0; no done pulse.
- IDLE, start=1, op=5: lo<=a, same rules as op=4.
- IDLE, start=1, op in {6,7}: ignored.
- CALC:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring-division step per cycle.
  - Counter runs 0..WIDTH-1, then the unit enters FIX.
- FIX edge:
  - Negate results as required, write hi/lo, set done=1 for exactly one cycle, clear busy, go to IDLE.
- Latency: start accepted at edge k → hi/lo and done visible after edge k+WIDTH+1 (33 for WIDTH=32). busy is high for cycles k+1..k+WIDTH+1.
- Multiply results: hi:lo = full 2*WIDTH-bit product.
  - MULT: two's-complement product.
  - MULTU: unsigned product.
- Divide results: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide by zero (b=0): lo = all ones, hi = a (original, unmodified). The unit still takes the full latency.
- Signed overflow (DIV, a = most negative, b = -1): lo = most negative, hi = 0.
- start while busy: ignored. Operands are not re-latched and hi/lo are undisturbed.
- flush=1:
  - From CALC or FIX: go to IDLE next edge, busy=0, no done, hi/lo unchanged.
  - In IDLE: no effect; flush has priority over start in the same cycle.
- A new start in the cycle done is high is accepted normally, since the unit is already IDLE.
- hi/lo are stable and directly readable at all times other than their commit edge.

Decomposition:
- Shared package holds:
  - op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO);
  - state encoding constants (ST_IDLE, ST_CALC, ST_FIX);
  - the counter width, derived from WIDTH.
- One sub-module is natural: muldiv_step.
  - Combinational, single iteration: selects the shift-add or restore-subtract step from an is_div flag.
- The FSM, operand latching, sign fix and HI/LO registers stay in muldiv_unit.

Test Plan:
- Reset mid-CALC:
  - Stimulus: start MULT a=5 b=7; assert rst at cycle 10.
  - Response: busy=0, done=0, hi=0, lo=0 next cycle; no done pulse afterwards.
- MULT a=0xFFFFFFFF (-1), b=2 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- start while busy and flush:
  - Stimulus: start DIVU 100/7; at cycle 5 assert start MTHI a=0x1234; at cycle 20 assert flush.
  - Response: MTHI is ignored; busy drops after the flush edge; done never pulses; hi/lo keep their pre-operation values.
- Back-to-back and direct writes:
  - Stimulus: MTLO a=0xABCD, then MTHI a=0x1 on consecutive cycles.
  - Response: lo=0xABCD and hi=0x1 each one edge after their request; busy stays 0 throughout.
  - Stimulus: issue MULTU 3*4 in the done cycle of a previous op.
  - Response: lo=12 after 33 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - op encodings driven on muldiv_unit.op
//   - FSM state encoding
//   - iteration counter width helper
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Bits needed to count 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multi-cycle datapath.
//   is_div   : 1 = restoring-division step, 0 = shift-add multiply step
//   acc      : multiply upper product half / division partial remainder
//   q        : multiply lower product half (multiplier) / dividend-quotient shift register
//   m        : multiplicand or divisor magnitude
//   acc_next, q_next : state after this iteration
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier LSB is set, then
    // shift the whole {carry, acc, q} right by one.
    sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    // Divide: bring the next dividend bit into the partial remainder.
    shifted = {acc, q[WIDTH-1]};
    ge      = (shifted >= {1'b0, m});
    // Remainder stays below m, so the low WIDTH bits of the difference suffice.
    diff    = shifted[WIDTH-1:0] - m;
    if (is_div) begin
      acc_next = ge ? diff : shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], ge};
    end else begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed/unsigned multiply and divide with HI/LO registers.
//   clk, rst     : clock and synchronous active-high reset
//   start, op    : request and operation (MULT, MULTU, DIV, DIVU, MTHI, MTLO; 6/7 no-op)
//   a, b         : operands (a also carries MTHI/MTLO data)
//   flush        : abort an in-flight operation without touching hi/lo
//   busy         : operation in progress
//   done         : one-cycle pulse after a MULT/DIV commit to hi/lo
//   hi, lo       : architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] step_acc, step_q;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .q       (q_q),
    .m       (m_q),
    .acc_next(step_acc),
    .q_next  (step_q)
  );

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    // Operand preparation for an incoming request.
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_abs     = a_neg ? (~a + 1'b1) : a;
    b_abs     = b_neg ? (~b + 1'b1) : b;

    // Sign correction of the magnitude results.
    prod      = {acc_q, q_q};
    prod_fix  = neg_res_q ? (~prod + 1'b1) : prod;
    quot_fix  = neg_res_q ? (~q_q + 1'b1) : q_q;
    rem_fix   = neg_rem_q ? (~acc_q + 1'b1) : acc_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    q_d        = q_q;
    m_d        = m_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        // Flush wins over start in the same cycle.
        if (start && !flush) begin
          if (op[2] == 1'b0) begin
            state_d    = ST_CALC;
            busy_d     = 1'b1;
            cnt_d      = '0;
            acc_d      = '0;
            q_d        = a_abs;
            m_d        = b_abs;
            a_raw_d    = a;
            is_div_d   = op[1];
            neg_res_d  = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            div_zero_d = (b == '0);
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end

      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = step_acc;
          q_d   = step_q;
          if (cnt_q == CntLast) begin
            state_d = ST_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (div_zero_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      m_q        <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      m_q        <= m_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
